sprite_compositor: RTL

Per-pixel colour source for the 128x128 SSD1351 OLED path. It sits between the `oled_video` scan driver and the 16x16 sprite bitmap ROM. It follows the driver's `x`/`y` scan position and prefetches the current scanline's 16-bit sprite row from the byte-wide ROM. It then drives a registered RGB565 `color`: foreground where the sprite bit is set inside the sprite window, background elsewhere.

---
 rtl/sprite_compositor_if.sv | 51 +++++
 rtl/sprite_compositor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sprite_compositor_if.sv
// ---------------------------------------------------------------------------
// sprite_compositor_if
//   Bundles the scan-position, sprite-setup, ROM and pixel-colour signals that
//   connect the sprite compositor to the OLED scan driver and the sprite ROM.
//
//   master : the scan driver plus the sprite ROM. It drives x, y, next_pixel,
//            the sprite setup and colours, and rom_bits. It receives rom_addr,
//            color and busy.
//   slave  : the compositor. It receives scan/setup/ROM data and drives
//            rom_addr, color and busy.
//
//   Signals
//     x, y        current scan column / row
//     next_pixel  driver consumed color (informational only)
//     sprite_x/y  sprite top-left corner, frame_sel sprite frame index
//     fg_color    RGB565 colour for set sprite bits, bg_color for the rest
//     rom_addr    ROM byte address {frame, row, half}, rom_bits ROM data
//     color       registered RGB565 pixel colour, busy row fetch in flight
// ---------------------------------------------------------------------------
interface sprite_compositor_if #(
    parameter int X_SIZE = 128,
    parameter int Y_SIZE = 128
);
    localparam int XW = $clog2(X_SIZE);
    localparam int YW = $clog2(Y_SIZE);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          next_pixel;
    logic [XW-1:0] sprite_x;
    logic [YW-1:0] sprite_y;
    logic [2:0]    frame_sel;
    logic [15:0]   fg_color;
    logic [15:0]   bg_color;
    logic [7:0]    rom_addr;
    logic [7:0]    rom_bits;
    logic [15:0]   color;
    logic          busy;

    modport master (
        output x, y, next_pixel, sprite_x, sprite_y, frame_sel,
               fg_color, bg_color, rom_bits,
        input  rom_addr, color, busy
    );

    modport slave (
        input  x, y, next_pixel, sprite_x, sprite_y, frame_sel,
               fg_color, bg_color, rom_bits,
        output rom_addr, color, busy
    );
endinterface

// File: rtl/sprite_compositor.sv
// ---------------------------------------------------------------------------
// sprite_compositor
//   Per-pixel colour source for the 128x128 OLED path. The block follows the
//   scan position from the video driver. Whenever the row changes, it fetches
//   that row's 16-bit sprite line from the byte-wide ROM (low byte, then high
//   byte). It then registers fg_color where the sprite bit under (x,y) is set
//   and bg_color everywhere else.
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    sprite_compositor_if.slave (scan position, sprite setup,
//            colours, ROM address/data, pixel colour, busy)
//
//   Sprite position and frame are sampled only when a fetch for row 0
//   starts, so they stay constant over a frame. The sprite is clipped at
//   the right and bottom edges; unsigned differences with a borrow bit keep
//   it from wrapping to column/row 0.
// ---------------------------------------------------------------------------
module sprite_compositor #(
    parameter int X_SIZE = 128,
    parameter int Y_SIZE = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    sprite_compositor_if.slave  bus
);
    localparam int XW = $clog2(X_SIZE);
    localparam int YW = $clog2(Y_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET_LO = 3'd1,
        ST_CAP_LO = 3'd2,
        ST_SET_HI = 3'd3,
        ST_CAP_HI = 3'd4
    } state_t;

    state_t        state_r;
    logic          busy_r;
    logic          start_r;      // forces one fetch right after reset
    logic [YW-1:0] last_y_r;     // row whose line is held in active_r
    logic [YW-1:0] fetch_y_r;    // row the in-flight fetch belongs to
    logic [XW-1:0] sx_r;
    logic [YW-1:0] sy_r;
    logic [2:0]    frm_r;
    logic [7:0]    shadow_lo_r;  // low byte waiting for its high byte
    logic [15:0]   active_r;     // sprite line used for colouring
    logic [7:0]    rom_addr_r;
    logic [15:0]   color_r;

    logic [XW:0]   dx_s;
    logic [YW:0]   dy_s;
    logic          x_win_s;
    logic          y_win_s;
    logic [3:0]    row_s;
    logic          hit_s;
    logic          fetch_go_s;

    // window decode, sprite hit and fetch start/restart request
    always_comb begin
        dx_s    = {1'b0, bus.x} - {1'b0, sx_r};
        dy_s    = {1'b0, bus.y} - {1'b0, sy_r};
        // borrow bit set or distance >= 16 both mean outside the sprite
        x_win_s = (dx_s[XW:4] == '0);
        y_win_s = (dy_s[YW:4] == '0);
        row_s   = dy_s[3:0];
        hit_s   = x_win_s && active_r[dx_s[3:0]];
        if (state_r == ST_IDLE) begin
            fetch_go_s = start_r || (bus.y != last_y_r);
        end else begin
            // a row change mid-fetch discards the partial line and restarts
            fetch_go_s = (bus.y != fetch_y_r);
        end
    end

    // row fetch state machine with frame-start sampling and line registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            start_r     <= 1'b1;
            last_y_r    <= '1;
            fetch_y_r   <= '0;
            sx_r        <= '0;
            sy_r        <= '0;
            frm_r       <= 3'd0;
            shadow_lo_r <= 8'h00;
            active_r    <= 16'h0000;
            rom_addr_r  <= 8'h00;
        end else if (fetch_go_s) begin
            // restart wins over every state, including CAP_HI
            state_r   <= ST_SET_LO;
            busy_r    <= 1'b1;
            start_r   <= 1'b0;
            fetch_y_r <= bus.y;
            if (bus.y == '0) begin
                sx_r  <= bus.sprite_x;
                sy_r  <= bus.sprite_y;
                frm_r <= bus.frame_sel;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    busy_r <= 1'b0;
                end
                ST_SET_LO: begin
                    // outside the vertical window the ROM is left untouched
                    if (y_win_s) begin
                        rom_addr_r <= {frm_r, row_s, 1'b0};
                    end
                    state_r <= ST_CAP_LO;
                end
                ST_CAP_LO: begin
                    shadow_lo_r <= bus.rom_bits;
                    state_r     <= ST_SET_HI;
                end
                ST_SET_HI: begin
                    if (y_win_s) begin
                        rom_addr_r <= {frm_r, row_s, 1'b1};
                    end
                    state_r <= ST_CAP_HI;
                end
                ST_CAP_HI: begin
                    active_r <= y_win_s ? {bus.rom_bits, shadow_lo_r} : 16'h0000;
                    last_y_r <= bus.y;
                    state_r  <= ST_IDLE;
                    busy_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // pixel colour register, one cycle behind x/y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_r <= 16'h0000;
        end else begin
            color_r <= hit_s ? bus.fg_color : bus.bg_color;
        end
    end

    assign bus.color    = color_r;
    assign bus.rom_addr = rom_addr_r;
    assign bus.busy     = busy_r;

endmodule
